posit_add_scheduler: RTL
========================

POSIT_ADD_SCHEDULER -- requirements
Module: posit_add_scheduler

Interface
REQ-001 SHALL have parameter N, default 32: posit word width.
REQ-002 SHALL have parameter ES, default 2: posit exponent field width.
REQ-003 SHALL have parameter NREQ, default 4: number of requesters; IDW = $clog2(NREQ).
REQ-004 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port req_valid, input, NREQ: per-requester operation request.
REQ-007 SHALL have port req_ready, output, NREQ: per-requester accept; one-hot or zero.
REQ-008 SHALL have port req_a, input, NREQ*N: operand A; requester i at bits [i*N +: N].
REQ-009 SHALL have port req_b, input, NREQ*N: operand B, same packing as req_a.
REQ-010 SHALL have port req_sub, input, NREQ: 1 = A-B, 0 = A+B.
REQ-011 SHALL have port res_valid, output, 1: result available.
REQ-012 SHALL have port res_ready, input, 1: consumer accepts result.
REQ-013 SHALL have port res_data, output, N: posit sum/difference.
REQ-014 SHALL have port res_id, output, IDW: index of the requester owning res_data.
REQ-015 SHALL have port busy, output, 1: either pipeline stage occupied.

Function
REQ-016 SHALL instantiate exactly one Optimised_PA #(N,ES) adder, shared by all requesters.
REQ-017 SHALL use two stages: S1 operand register (a, b', id, v1) feeding the adder; S2 result register (res_data, res_id, res_valid) capturing adder OUT.
REQ-018 SHALL set b' = b for add; for sub, b' = two's-complement negation of b (NaR 0x80..0 and zero map to themselves by construction).
REQ-019 SHALL define s2_free = !res_valid || res_ready; s1_free = !v1 || s2_free.
REQ-020 SHALL grant at most one requester per cycle, only when s1_free; req_ready[g] = 1 combinationally for the granted g, only if req_valid[g].
REQ-021 SHALL arbitrate round-robin: search starts at pointer ptr, ascending index with wrap at NREQ-1 -> 0.
REQ-022 SHALL update ptr to (g+1) mod NREQ on a grant; ptr SHALL hold when no grant.
REQ-023 SHALL load S1 on a grant; v1 SHALL clear when S1 moves to S2 with no new grant.
REQ-024 SHALL move S1 to S2 when v1 && s2_free; res_valid SHALL clear on res_ready with nothing moving in.
REQ-025 SHALL give latency 2: grant in cycle t -> res_valid high in cycle t+2 with no backpressure.
REQ-026 SHALL sustain one result per cycle throughput when res_ready is held high.
REQ-027 SHALL hold res_data/res_id stable while res_valid && !res_ready; S1 holds, no grants when S1 full and stalled.
REQ-028 SHALL allow simultaneous S2 drain, S1->S2 move and new grant in one cycle.
REQ-029 SHALL accept requests regardless of ID ordering; results SHALL return in grant order.
REQ-030 SHALL assert busy = v1 || res_valid.
REQ-031 SHALL not inspect operand values; NaR/zero handling is the adder's.

Reset
REQ-032 SHALL, on rst high at a clock edge, clear v1, res_valid, res_data, res_id and set ptr = 0; req_ready SHALL read 0 while rst is high.
REQ-033 SHALL discard in-flight operations on reset mid-operation; no result for them SHALL appear after reset.

Verification (N=32, ES=2)
REQ-034 SHALL test single add: req 0 a=0x40000000, b=0x40000000, sub=0 -> 2 cycles later res_valid=1, res_data=0x48000000, res_id=0.
REQ-035 SHALL test subtract: req 2 a=0x40000000, b=0x40000000, sub=1 -> res_data=0x00000000, res_id=2.
REQ-036 SHALL test fairness: all 4 req_valid held high, res_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; res_id sequence matches.
REQ-037 SHALL test backpressure: res_ready=0 for 5 cycles with requests pending -> exactly 2 ops accepted, res_data stable; on release, in-order drain with no loss or duplication.
REQ-038 SHALL test NaR: a=0x80000000, b=0x40000000 -> res_data=0x80000000.
REQ-039 SHALL test reset with S1 and S2 full -> next cycle res_valid=0, busy=0, ptr=0; first grant after reset goes to lowest valid index.

Source files
------------

// File: rtl/posit_add_scheduler.sv
// rtl/posit_add_scheduler.sv - round-robin scheduler sharing one two-stage posit adder among requesters
module Optimised_PA #(
  parameter int N  = 32,
  parameter int ES = 2
) (
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  output logic [N-1:0] out
);
  localparam int FW = N - ES;
  localparam int MW = FW + 5;
  localparam int SW = $clog2(N) + ES + 4;
  localparam int LW = 2 + ES + (MW - 1) + N;
  localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

  // Splits a posit into sign, scale (regime*2^ES + exponent) and significand with hidden one.
  function automatic void decode(input logic [N-1:0] p, output logic sgn,
                                 output logic signed [SW-1:0] sc, output logic [FW:0] mant);
    logic [N-1:0] x;
    logic [N-1:0] rem;
    logic signed [SW-1:0] r;
    int k;
    x = p[N-1] ? -p : p;
    k = 0;
    for (int i = N-2; i >= 0; i--)
      if (x[i] == x[N-2] && k == N-2-i) k++;
    r = x[N-2] ? SW'(k - 1) : -SW'(k);
    rem = x << (k + 2);
    sgn = p[N-1];
    sc = (r <<< ES) + SW'(rem[N-1 -: ES]);
    mant = {1'b1, rem[N-1-ES:0]};
  endfunction

  logic                 sa, sb, sg, sl, swap, guard, sticky, lz_done;
  logic signed [SW-1:0] ea, eb, eg, el, d, rsc, r, nr;
  logic [FW:0]          ma, mb, mg, ml;
  logic [MW-1:0]        small_ext, al, ag, s, nm;
  logic [LW-1:0]        ev;
  logic [N-2:0]         body, rnd;
  logic [N-1:0]         mag;
  int                   dsh, lz;

  always_comb begin
    decode(in1, sa, ea, ma);
    decode(in2, sb, eb, mb);
    swap = (eb > ea) || ((eb == ea) && (mb > ma));
    sg = swap ? sb : sa;
    sl = swap ? sa : sb;
    eg = swap ? eb : ea;
    el = swap ? ea : eb;
    mg = swap ? mb : ma;
    ml = swap ? ma : mb;
    d = eg - el;
    dsh = (d > MW) ? MW : int'(d);
    // Three extra low bits act as guard/round/sticky for the aligned smaller operand.
    small_ext = {1'b0, ml, 3'b000};
    al = small_ext >> dsh;
    al[0] = al[0] | (|(small_ext & ~({MW{1'b1}} << dsh)));
    ag = {1'b0, mg, 3'b000};
    s = (sg == sl) ? ag + al : ag - al;
    lz = 0;
    lz_done = 1'b0;
    for (int i = MW-1; i >= 0; i--) begin
      if (!lz_done) begin
        if (s[i]) lz_done = 1'b1;
        else lz++;
      end
    end
    nm = s << lz;
    rsc = eg + SW'(1) - SW'(lz);
    r = rsc >>> ES;
    nr = -r - SW'(1);
    // Regime is built by shifting a 10/01 seed; shifted-past bits fall into guard/sticky.
    if (!r[SW-1])
      ev = $signed({2'b10, rsc[ES-1:0], nm[MW-2:0], {N{1'b0}}}) >>> ((r > N) ? N : int'(r));
    else
      ev = {2'b01, rsc[ES-1:0], nm[MW-2:0], {N{1'b0}}} >> ((nr > N) ? N : int'(nr));
    body = ev[LW-1 -: N-1];
    guard = ev[LW-N];
    sticky = |ev[LW-N-1:0];
    rnd = body + {{(N-2){1'b0}}, guard & (body[0] | sticky) & ~(&body)};
    if (rnd == '0) rnd = {{(N-2){1'b0}}, 1'b1};
    mag = {1'b0, rnd};
    if (in1 == NAR || in2 == NAR) out = NAR;
    else if (in1 == '0) out = in2;
    else if (in2 == '0) out = in1;
    else if (!nm[MW-1]) out = '0;
    else out = sg ? -mag : mag;
  end
endmodule

module posit_add_scheduler #(
  parameter  int N    = 32,
  parameter  int ES   = 2,
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  input  logic [NREQ-1:0]   req_sub,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [N-1:0]      res_data,
  output logic [IDW-1:0]    res_id,
  output logic              busy
);
  logic           v1, s1_free, s2_free, move, grant, gnt_found;
  logic [N-1:0]   s1_a, s1_b, b_op, add_out;
  logic [IDW-1:0] s1_id, ptr, ptr_next, gnt_idx;
  int             idx;

  assign s2_free = !res_valid || res_ready;
  assign s1_free = !v1 || s2_free;
  assign move    = v1 && s2_free;
  assign busy    = v1 || res_valid;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx = '0;
    idx = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx = IDW'(idx);
      end
    end
    grant = gnt_found && s1_free && !rst;
    req_ready = grant ? (NREQ'(1) << gnt_idx) : '0;
    ptr_next = (int'(gnt_idx) == NREQ-1) ? '0 : gnt_idx + 1'b1;
    b_op = req_sub[gnt_idx] ? -req_b[gnt_idx*N +: N] : req_b[gnt_idx*N +: N];
  end

  Optimised_PA #(.N(N), .ES(ES)) u_pa (
    .in1(s1_a),
    .in2(s1_b),
    .out(add_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_id     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
      ptr       <= '0;
    end else begin
      if (grant) begin
        v1    <= 1'b1;
        s1_a  <= req_a[gnt_idx*N +: N];
        s1_b  <= b_op;
        s1_id <= gnt_idx;
        ptr   <= ptr_next;
      end else if (move) begin
        v1 <= 1'b0;
      end
      if (move) begin
        res_valid <= 1'b1;
        res_data  <= add_out;
        res_id    <= s1_id;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end
endmodule
